// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin values, FSM states,
// error codes and the refill/denomination select encoding.
package vend_pkg;

    localparam int AMOUNT_W = 7;
    localparam int INV_W    = 6;

    localparam logic [AMOUNT_W-1:0] COIN_5     = 7'd5;
    localparam logic [AMOUNT_W-1:0] COIN_10    = 7'd10;
    localparam logic [AMOUNT_W-1:0] COIN_25    = 7'd25;
    localparam logic [AMOUNT_W-1:0] MAX_AMOUNT = 7'd125;
    localparam logic [INV_W-1:0]    INV_MAX    = 6'd63;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_BAD_AMOUNT = 2'b01,
        ERR_NO_COINS   = 2'b10,
        ERR_TIMEOUT    = 2'b11
    } err_code_t;

    // Same encoding is used for refill_sel and for the chosen denomination.
    typedef enum logic [1:0] {
        SEL_5    = 2'd0,
        SEL_10   = 2'd1,
        SEL_25   = 2'd2,
        SEL_NONE = 2'd3
    } coin_sel_t;

    function automatic logic [AMOUNT_W-1:0] coin_value(input coin_sel_t sel);
        case (sel)
            SEL_5:   coin_value = COIN_5;
            SEL_10:  coin_value = COIN_10;
            SEL_25:  coin_value = COIN_25;
            default: coin_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper, refill and status signals of the change dispenser.
// master drives requests (controller/bench), slave is the dispenser.
interface change_dispenser_if;
    import vend_pkg::*;

    logic                start;
    logic [AMOUNT_W-1:0] amount;
    logic                hopper_ack;
    logic                refill_valid;
    logic [1:0]          refill_sel;
    logic [INV_W-1:0]    refill_qty;

    logic                eject_5;
    logic                eject_10;
    logic                eject_25;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;
    logic [AMOUNT_W-1:0] remaining;
    logic [INV_W-1:0]    inv_5;
    logic [INV_W-1:0]    inv_10;
    logic [INV_W-1:0]    inv_25;

    modport master (
        output start, amount, hopper_ack, refill_valid, refill_sel, refill_qty,
        input  eject_5, eject_10, eject_25, busy, done, error, err_code,
               remaining, inv_5, inv_10, inv_25
    );

    modport slave (
        input  start, amount, hopper_ack, refill_valid, refill_sel, refill_qty,
        output eject_5, eject_10, eject_25, busy, done, error, err_code,
               remaining, inv_5, inv_10, inv_25
    );

endinterface

// File: rtl/coin_inventory.sv
// Three saturating 6-bit coin counters; each can take an eject decrement
// and a refill in the same cycle.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int INIT_INV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  coin_sel_t        dec_sel,
    input  logic             refill_valid,
    input  coin_sel_t        refill_sel,
    input  logic [INV_W-1:0] refill_qty,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_10,
    output logic [INV_W-1:0] inv_25
);

    logic [INV_W-1:0] count_bus [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_counter
            logic [INV_W-1:0] count_reg;
            logic [INV_W-1:0] count_next;
            logic [INV_W-1:0] after_dec;
            logic [INV_W:0]   sum;

            // Decrement first, then add the refill; the extra sum bit flags saturation.
            always_comb begin
                after_dec = count_reg;
                if (dec_valid && (dec_sel == coin_sel_t'(2'(gi))))
                    after_dec = count_reg - 1'b1;
                sum = {1'b0, after_dec};
                if (refill_valid && (refill_sel == coin_sel_t'(2'(gi))))
                    sum = {1'b0, after_dec} + {1'b0, refill_qty};
                count_next = sum[INV_W] ? INV_MAX : sum[INV_W-1:0];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    count_reg <= INV_W'(INIT_INV);
                else
                    count_reg <= count_next;
            end

            assign count_bus[gi] = count_reg;
        end
    endgenerate

    assign inv_5  = count_bus[0];
    assign inv_10 = count_bus[1];
    assign inv_25 = count_bus[2];

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin change dispenser: picks 25/10/5 coins from inventory, pulses
// the hopper and waits for each drop acknowledge with a timeout.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INIT_INV       = 10
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_reg,     state_next;
    logic [AMOUNT_W-1:0] remaining_reg, remaining_next;
    err_code_t           err_code_reg,  err_code_next;
    coin_sel_t           coin_reg,      coin_next;
    logic [TIMER_W-1:0]  timer_reg,     timer_next;

    coin_sel_t           pick;
    logic                amount_ok;
    logic [INV_W-1:0]    inv_5;
    logic [INV_W-1:0]    inv_10;
    logic [INV_W-1:0]    inv_25;

    coin_inventory #(
        .INIT_INV (INIT_INV)
    ) u_inventory (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (state_reg == EJECT),
        .dec_sel      (coin_reg),
        .refill_valid (bus.refill_valid),
        .refill_sel   (coin_sel_t'(bus.refill_sel)),
        .refill_qty   (bus.refill_qty),
        .inv_5        (inv_5),
        .inv_10       (inv_10),
        .inv_25       (inv_25)
    );

    assign amount_ok = (bus.amount <= MAX_AMOUNT) && ((bus.amount % 7'd5) == 7'd0);

    // Largest coin that still fits and is in stock; no backtracking.
    always_comb begin
        pick = SEL_NONE;
        if ((remaining_reg >= COIN_25) && (inv_25 != '0))
            pick = SEL_25;
        else if ((remaining_reg >= COIN_10) && (inv_10 != '0))
            pick = SEL_10;
        else if ((remaining_reg >= COIN_5) && (inv_5 != '0))
            pick = SEL_5;
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        err_code_next  = err_code_reg;
        coin_next      = coin_reg;
        timer_next     = timer_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (amount_ok) begin
                        remaining_next = bus.amount;
                        err_code_next  = ERR_NONE;
                        state_next     = SELECT;
                    end else begin
                        err_code_next  = ERR_BAD_AMOUNT;
                        state_next     = ERR;
                    end
                end
            end
            SELECT: begin
                if (remaining_reg == '0) begin
                    state_next = DONE;
                end else if (pick == SEL_NONE) begin
                    err_code_next = ERR_NO_COINS;
                    state_next    = ERR;
                end else begin
                    coin_next  = pick;
                    state_next = EJECT;
                end
            end
            EJECT: begin
                timer_next = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack on the last timeout cycle still counts as a drop.
                if (bus.hopper_ack) begin
                    remaining_next = remaining_reg - coin_value(coin_reg);
                    state_next     = SELECT;
                end else if (timer_reg == TIMER_LAST) begin
                    err_code_next = ERR_TIMEOUT;
                    state_next    = ERR;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            err_code_reg  <= ERR_NONE;
            coin_reg      <= SEL_NONE;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            err_code_reg  <= err_code_next;
            coin_reg      <= coin_next;
            timer_reg     <= timer_next;
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.error     = (state_reg == ERR);
    assign bus.eject_5   = (state_reg == EJECT) && (coin_reg == SEL_5);
    assign bus.eject_10  = (state_reg == EJECT) && (coin_reg == SEL_10);
    assign bus.eject_25  = (state_reg == EJECT) && (coin_reg == SEL_25);
    assign bus.err_code  = err_code_reg;
    assign bus.remaining = remaining_reg;
    assign bus.inv_5     = inv_5;
    assign bus.inv_10    = inv_10;
    assign bus.inv_25    = inv_25;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The module SHALL take parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for hopper_ack after an eject pulse.
REQ-002 The module SHALL take parameter INIT_INV, default 10, meaning the coin count loaded into each denomination's inventory on reset.
REQ-003 The clock SHALL be clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-004 The reset SHALL be reset, input, 1 bit: asynchronous, active-high.
REQ-005 The module SHALL have input start, 1 bit: dispense request, sampled in IDLE only.
REQ-006 The module SHALL have input amount, 7 bits: change to pay in cents, latched when start is accepted.
REQ-007 The module SHALL have input hopper_ack, 1 bit: coin-dropped sensor pulse.
REQ-008 The module SHALL have inputs refill_valid (1 bit), refill_sel (2 bits: 0=5c, 1=10c, 2=25c, 3=no-op) and refill_qty (6 bits): an inventory top-up.
REQ-009 The module SHALL have outputs eject_5, eject_10 and eject_25, 1 bit each: one-cycle hopper commands.
REQ-010 The module SHALL have outputs busy, done and error, 1 bit each, and err_code, 2 bits: 01=bad amount, 10=insufficient coins, 11=hopper timeout.
REQ-011 The module SHALL have outputs remaining (7 bits: cents not yet dispensed) and inv_5, inv_10, inv_25 (6 bits each: coin counts).

Function
REQ-012 The FSM SHALL have states IDLE, SELECT, EJECT, WAIT_ACK, DONE and ERR; busy SHALL be high in every state except IDLE.
REQ-013 In IDLE, start with amount a multiple of 5 and no greater than 125 SHALL latch remaining=amount, clear err_code and move to SELECT.
REQ-014 In IDLE, start with any other amount SHALL set err_code=01 and move to ERR; remaining SHALL be left unchanged.
REQ-015 In SELECT, remaining==0 SHALL move to DONE; this covers amount 0.
REQ-016 Otherwise SELECT SHALL pick the largest denomination d with d<=remaining and inventory>0 (order 25, 10, 5) and move to EJECT.
REQ-017 If SELECT finds no such denomination, it SHALL set err_code=10 and move to ERR with remaining holding the undispensed cents.
REQ-018 Selection SHALL be strictly greedy; no backtracking is performed.
REQ-019 EJECT SHALL last exactly one cycle, asserting only the chosen eject_X, decrementing that inventory by 1 and clearing the timeout counter, then move to WAIT_ACK.
REQ-020 In WAIT_ACK, hopper_ack SHALL subtract d from remaining and move to SELECT.
REQ-021 In WAIT_ACK, the timeout counter SHALL increment each cycle; after TIMEOUT_CYCLES cycles without hopper_ack the FSM SHALL set err_code=11 and move to ERR; remaining SHALL stay unchanged and the inventory SHALL stay decremented.
REQ-022 If hopper_ack and the final timeout cycle coincide, ack SHALL win.
REQ-023 DONE SHALL assert done for one cycle and ERR SHALL assert error for one cycle; both then move to IDLE.
REQ-024 err_code SHALL hold its value until the next accepted start.
REQ-025 Latency: start sampled at cycle N SHALL give SELECT at N+1 and eject high at N+2.
REQ-026 Latency: the final hopper_ack sampled at cycle M SHALL give done high at M+2.
REQ-027 start while busy and hopper_ack outside WAIT_ACK SHALL be ignored.
REQ-028 refill_valid SHALL be accepted in any state and add refill_qty to the selected inventory, saturating at 63.
REQ-029 If a refill and an EJECT decrement hit the same denomination in one cycle, the result SHALL be min(63, inv-1+qty).
REQ-030 remaining arithmetic SHALL be 7-bit and SHALL never underflow, because the selection rule guarantees d<=remaining.

Reset
REQ-031 Reset SHALL force state=IDLE, all outputs except inv_* to 0 and inv_5=inv_10=inv_25=INIT_INV, including mid-operation; no eject SHALL be emitted after reset until a new start.

Structure
REQ-032 Shared package vend_pkg SHALL hold the coin value constants (5, 10, 25), the state enum, the err_code enum and the refill_sel encoding.
REQ-033 Sub-module coin_inventory SHALL hold the three saturating counters with their decrement and refill ports.

Verification
REQ-034 inv 10/10/10, start amount=40 -> eject_25, eject_10, eject_5 in order, each acked -> done, remaining=0, inv 9/9/9.
REQ-035 inv_25=1, inv_10=3, inv_5=0, amount=30 -> eject_25 then error with err_code=10, remaining=5, inv_25=0.
REQ-036 amount=7 -> error at N+1 with err_code=01, no eject; amount=0 -> done with no eject.
REQ-037 amount=10, hopper_ack withheld -> error with err_code=11 exactly TIMEOUT_CYCLES cycles after WAIT_ACK entry, remaining=10, inv_10=9.
REQ-038 The bench SHALL check three corner cases:
- refill sel=2, qty=5 in the EJECT cycle of a 25c coin with inv_25=60 -> inv_25=63.
- start during WAIT_ACK -> ignored.
- reset asserted in WAIT_ACK -> IDLE with inv back to INIT_INV.
